// File: rtl/dpram_arbiter.sv
// Two-client arbiter in front of a dual-port RAM: round-robin write channel on port A,
// round-robin read channel on port B, read-after-write collision deferral and read return routing.

module dpram_arb_client #(
  parameter int data_w = 18,
  parameter bit ID     = 1'b0
) (
  input  logic              req,
  input  logic              we,
  input  logic              ret_vld,
  input  logic              ret_id,
  input  logic [data_w-1:0] ram_dB,
  output logic              wr_cand,
  output logic              rd_cand,
  output logic              rvalid,
  output logic [data_w-1:0] rdata
);
  always_comb begin
    wr_cand = req & we;
    rd_cand = req & ~we;
    rvalid  = ret_vld & (ret_id == ID);
    rdata   = rvalid ? ram_dB : '0;
  end
endmodule

module dpram_arbiter #(
  parameter int addr_w = 8,
  parameter int data_w = 18,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [addr_w-1:0] c0_addr,
  input  logic [data_w-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [data_w-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [addr_w-1:0] c1_addr,
  input  logic [data_w-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [data_w-1:0] c1_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [addr_w-1:0] ram_addrA,
  output logic [addr_w-1:0] ram_addrB,
  output logic [data_w-1:0] ram_dA,
  input  logic [data_w-1:0] ram_dB,
  output logic [15:0]       coll_cnt
);
  localparam int NUM_CL = 2;

  typedef struct packed {
    logic vld;
    logic id;
  } ret_t;

  logic [NUM_CL-1:0]             req_a, we_a, wcand, rcand, rvalid_a;
  logic [NUM_CL-1:0][addr_w-1:0] addr_a;
  logic [NUM_CL-1:0][data_w-1:0] wdata_a, rdata_a;

  logic        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0] coll_cnt_q, coll_cnt_d;
  ret_t [RD_LAT:1] ret_pipe_q, ret_pipe_d;

  logic        w_act, r_act, w_win, r_win, coll, r_ok;
  logic [NUM_CL-1:0] gnt;
  ret_t        ret_in;

  assign req_a   = {c1_req, c0_req};
  assign we_a    = {c1_we, c0_we};
  assign addr_a  = {c1_addr, c0_addr};
  assign wdata_a = {c1_wdata, c0_wdata};

  for (genvar g = 0; g < NUM_CL; g++) begin : g_cl
    dpram_arb_client #(.data_w(data_w), .ID(1'(g))) u_cl (
      .req     (req_a[g]),
      .we      (we_a[g]),
      .ret_vld (ret_pipe_q[RD_LAT].vld),
      .ret_id  (ret_pipe_q[RD_LAT].id),
      .ram_dB  (ram_dB),
      .wr_cand (wcand[g]),
      .rd_cand (rcand[g]),
      .rvalid  (rvalid_a[g]),
      .rdata   (rdata_a[g])
    );
  end

  always_comb begin
    w_act = |wcand;
    r_act = |rcand;
    w_win = (&wcand) ? wptr_q : wcand[1];
    r_win = (&rcand) ? rptr_q : rcand[1];
    // Reads of the address being written this cycle are pushed back so they see the new data.
    coll  = w_act & r_act & (addr_a[w_win] == addr_a[r_win]);
    r_ok  = r_act & ~coll;

    gnt[0] = (w_act & ~w_win) | (r_ok & ~r_win);
    gnt[1] = (w_act &  w_win) | (r_ok &  r_win);

    wptr_d     = w_act ? ~w_win : wptr_q;
    rptr_d     = r_ok  ? ~r_win : rptr_q;
    coll_cnt_d = (coll && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

    ret_in.vld    = r_ok;
    ret_in.id     = r_win;
    ret_pipe_d[1] = ret_in;
    for (int i = 2; i <= RD_LAT; i++) ret_pipe_d[i] = ret_pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      coll_cnt_q <= '0;
      ret_pipe_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      coll_cnt_q <= coll_cnt_d;
      ret_pipe_q <= ret_pipe_d;
    end
  end

  // Grants and RAM controls are combinational, so they are masked directly while in reset.
  always_comb begin
    c0_gnt    = ~rst & gnt[0];
    c1_gnt    = ~rst & gnt[1];
    ram_we    = ~rst & w_act;
    ram_re    = ~rst & r_ok;
    ram_addrA = ram_we ? addr_a[w_win]  : '0;
    ram_dA    = ram_we ? wdata_a[w_win] : '0;
    ram_addrB = ram_re ? addr_a[r_win]  : '0;
    c0_rvalid = rvalid_a[0];
    c0_rdata  = rdata_a[0];
    c1_rvalid = rvalid_a[1];
    c1_rdata  = rdata_a[1];
    coll_cnt  = coll_cnt_q;
  end
endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural RAM model returning reads after RD_LAT cycles.

module tb_dpram_arbiter;
  localparam int AW = 8;
  localparam int DW = 18;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addrA, ram_addrB;
  logic [DW-1:0] ram_dA, ram_dB;
  logic [15:0]   coll_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.addr_w(AW), .data_w(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addrA(ram_addrA), .ram_addrB(ram_addrB),
    .ram_dA(ram_dA), .ram_dB(ram_dB), .coll_cnt(coll_cnt)
  );

  // RAM model: write on port A, registered read on port B delayed to RD_LAT cycles
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_pipe [RD_LAT];
  assign ram_dB = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addrA] <= ram_dA;
    if (ram_re) rd_pipe[0] <= mem[ram_addrB];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c0_req = r; c0_we = w; c0_addr = a; c0_wdata = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c1_req = r; c1_we = w; c1_addr = a; c1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b1;
    drv0(1, 1, 8'h10, 18'h5);
    drv1(1, 0, 8'h11, 18'h0);
    #3;
    check("rst_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd0);
    check("rst_ram", {30'd0, ram_we, ram_re}, 32'd0);
    check("rst_addr", {ram_addrA, ram_addrB}, 32'd0);
    check("rst_dA", ram_dA, 32'd0);
    check("rst_rv", {c1_rvalid, c0_rvalid, c0_rdata, c1_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("idle", {26'd0, ram_we, ram_re, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid}, 32'd0);
    end
    check("idle_coll", coll_cnt, 32'd0);
    check("idle_addr", {ram_addrA, ram_addrB}, 32'd0);

    // write then read back
    @(negedge clk); drv0(1, 1, 8'h10, 18'h2ABCD); #1;
    check("wr_gnt", c0_gnt, 1);
    check("wr_ram", {ram_we, ram_re}, 32'b10);
    check("wr_addrA", ram_addrA, 32'h10);
    check("wr_dA", ram_dA, 32'h2ABCD);
    @(negedge clk); drv0(0, 0, 0, 0); drv1(1, 0, 8'h10, 0); #1;
    check("rd_gnt", {c1_gnt, c0_gnt}, 32'b10);
    check("rd_ram", {ram_we, ram_re}, 32'b01);
    check("rd_addrB", ram_addrB, 32'h10);
    check("rd_idleA", {ram_addrA, ram_dA}, 32'd0);
    @(negedge clk); drv1(0, 0, 0, 0); #1;
    check("rd_early", c1_rvalid, 0);
    @(negedge clk); #1;
    check("rd_rvalid", {c1_rvalid, c0_rvalid}, 32'b10);
    check("rd_rdata", c1_rdata, 32'h2ABCD);
    @(negedge clk); #1;
    check("rd_pulse", {c1_rvalid, c1_rdata}, 32'd0);

    // single c1 write leaves wptr at 0
    @(negedge clk); drv1(1, 1, 8'h40, 18'h00777); #1;
    check("c1_wr", c1_gnt, 1);
    @(negedge clk); drv1(0, 0, 0, 0);

    // write round robin
    @(negedge clk);
    drv0(1, 1, 8'h30, 18'h22222);
    drv1(1, 1, 8'h31, 18'h11111);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt", {c1_gnt, c0_gnt}, (i % 2 == 0) ? 32'b01 : 32'b10);
      check("rr_addrA", ram_addrA, (i % 2 == 0) ? 32'h30 : 32'h31);
      @(negedge clk);
    end
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);

    // collision
    @(negedge clk); drv0(1, 1, 8'h20, 18'h1F00F); drv1(1, 0, 8'h20, 0); #1;
    check("col_gnt", {c1_gnt, c0_gnt}, 32'b01);
    check("col_ram", {ram_we, ram_re}, 32'b10);
    check("col_addrB", ram_addrB, 32'd0);
    check("col_cnt0", coll_cnt, 32'd0);
    @(negedge clk); drv0(0, 0, 0, 0); #1;
    check("col_cnt1", coll_cnt, 32'd1);
    check("col_retry", {c1_gnt, ram_re}, 32'b11);
    check("col_addrB2", ram_addrB, 32'h20);
    @(negedge clk); drv1(0, 0, 0, 0);
    @(negedge clk); #1;
    check("col_rdata", {c1_rvalid, c1_rdata}, {13'd0, 1'b1, 18'h1F00F});

    // preload 0x05, then simultaneous read/write on different addresses
    @(negedge clk); drv1(1, 1, 8'h05, 18'h12345); #1;
    check("pre_wr", c1_gnt, 1);
    @(negedge clk); drv0(1, 0, 8'h05, 0); drv1(1, 1, 8'h06, 18'h00555); #1;
    check("rw_gnt", {c1_gnt, c0_gnt}, 32'b11);
    check("rw_ram", {ram_we, ram_re}, 32'b11);
    check("rw_addr", {ram_addrA, ram_addrB}, 32'h0605);
    check("rw_dA", ram_dA, 32'h00555);
    @(negedge clk); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); #1;
    check("rw_early", c0_rvalid, 0);
    @(negedge clk); #1;
    check("rw_rvalid", {c1_rvalid, c0_rvalid}, 32'b01);
    check("rw_rdata", c0_rdata, 32'h12345);
    check("rw_coll", coll_cnt, 32'd1);

    // read round robin: rptr now favours c1; returns in grant order
    @(negedge clk); drv0(1, 0, 8'h05, 0); drv1(1, 0, 8'h10, 0); #1;
    check("rrr_gnt1", {c1_gnt, c0_gnt}, 32'b10);
    check("rrr_addr1", ram_addrB, 32'h10);
    @(negedge clk); drv1(0, 0, 0, 0); #1;
    check("rrr_gnt0", {c1_gnt, c0_gnt}, 32'b01);
    check("rrr_addr0", ram_addrB, 32'h05);
    @(negedge clk); drv0(0, 0, 0, 0); #1;
    check("rrr_ret1", {c1_rvalid, c0_rvalid}, 32'b10);
    check("rrr_data1", c1_rdata, 32'h2ABCD);
    @(negedge clk); #1;
    check("rrr_ret0", {c1_rvalid, c0_rvalid}, 32'b01);
    check("rrr_data0", c0_rdata, 32'h12345);

    // c0 write moves wptr to 1, then reset with a read in flight
    @(negedge clk); drv0(1, 1, 8'h60, 18'h3); #1;
    check("pre6_wr", c0_gnt, 1);
    @(negedge clk); drv0(1, 0, 8'h10, 0); #1;
    check("r6_gnt", c0_gnt, 1);
    @(negedge clk); drv0(0, 0, 0, 0); rst = 1'b1; #1;
    check("r6_rst", {c1_rvalid, c0_rvalid, coll_cnt}, 32'd0);
    @(negedge clk); #1;
    check("r6_rst2", {c1_rvalid, c0_rvalid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("r6_norv", {c1_rvalid, c0_rvalid}, 32'd0);
    end
    @(negedge clk); drv0(1, 1, 8'h70, 18'h1); drv1(1, 1, 8'h71, 18'h2); #1;
    check("r6_wptr", {c1_gnt, c0_gnt}, 32'b01);
    @(negedge clk); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    @(negedge clk); drv0(1, 0, 8'h70, 0); drv1(1, 0, 8'h71, 0); #1;
    check("r6_rptr", {c1_gnt, c0_gnt}, 32'b01);
    @(negedge clk); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
